// File: rtl/multicycle_control_fsm_pkg.sv
// Shared control definitions for the RV32I lab CPU.
// Used by the sequencer, the datapath and ALU control.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_FUNCT  = 2'b01;
    localparam logic [1:0] ALU_BRANCH = 2'b10;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_IMM   = 2'b01;
    localparam logic [1:0] PC_ALU   = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MDR = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    typedef struct packed {
        logic r;
        logic i;
        logic load;
        logic store;
        logic branch;
        logic jal;
        logic jalr;
        logic ecall;
        logic illegal;
    } op_class_t;

endpackage

// File: rtl/multicycle_control_fsm_decode.sv
// Opcode classifier: maps IR[6:0] to a one-hot instruction class.
// Anything outside the supported RV32I subset lands in the illegal class.
module opcode_class_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_t  op_class
);

    // One-hot class lookup on the major opcode.
    always_comb begin
        op_class = '0;
        case (opcode)
            OP_R:      op_class.r       = 1'b1;
            OP_I:      op_class.i       = 1'b1;
            OP_LOAD:   op_class.load    = 1'b1;
            OP_STORE:  op_class.store   = 1'b1;
            OP_BRANCH: op_class.branch  = 1'b1;
            OP_JAL:    op_class.jal     = 1'b1;
            OP_JALR:   op_class.jalr    = 1'b1;
            OP_ECALL:  op_class.ecall   = 1'b1;
            default:   op_class.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer for the RV32I lab CPU.
// Drives datapath enables, stalls on mem_ready, halts on exit ecall.
module multicycle_control_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             alu_bcond,
    input  logic             is_halted,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic [1:0]       pc_source,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             alu_src_a,
    output logic             alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    state_e           state_q, state_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] instret_cnt_q, instret_cnt_d;
    op_class_t        cls;

    opcode_class_decode u_dec (
        .opcode   (opcode),
        .op_class (cls)
    );

    // State, halt flag and counters; reset returns to a fresh IF.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IF;
            halted_q      <= 1'b0;
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            halted_q      <= halted_d;
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    // Next-state and enable decode; reset forces every enable low at once.
    always_comb begin
        state_d   = state_q;
        halted_d  = halted_q;
        pc_write  = 1'b0;
        pc_source = PC_PLUS4;
        iord      = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        alu_op    = ALU_ADD;
        reg_write = 1'b0;
        wb_sel    = WB_ALU;
        illegal   = 1'b0;

        unique case (state_q)
            ST_IF: begin
                mem_read = 1'b1;
                ir_write = mem_ready;
                if (mem_ready) begin
                    state_d = ST_ID;
                end
            end
            ST_ID: begin
                if (cls.ecall && is_halted) begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                end else if (cls.ecall || cls.illegal) begin
                    illegal  = cls.illegal;
                    pc_write = 1'b1;
                    state_d  = ST_IF;
                end else begin
                    state_d = ST_EX;
                end
            end
            ST_EX: begin
                unique case (1'b1)
                    cls.r: begin
                        alu_src_a = 1'b1;
                        alu_op    = ALU_FUNCT;
                        state_d   = ST_WB;
                    end
                    cls.i: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 1'b1;
                        alu_op    = ALU_FUNCT;
                        state_d   = ST_WB;
                    end
                    cls.load, cls.store: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 1'b1;
                        state_d   = ST_MEM;
                    end
                    cls.branch: begin
                        alu_src_a = 1'b1;
                        alu_op    = ALU_BRANCH;
                        pc_write  = 1'b1;
                        pc_source = alu_bcond ? PC_IMM : PC_PLUS4;
                        state_d   = ST_IF;
                    end
                    cls.jal: begin
                        state_d = ST_WB;
                    end
                    cls.jalr: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 1'b1;
                        state_d   = ST_WB;
                    end
                    default: begin
                        state_d = ST_IF;
                    end
                endcase
            end
            ST_MEM: begin
                iord = 1'b1;
                if (cls.load) begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        state_d = ST_WB;
                    end
                end else if (cls.store) begin
                    mem_write = 1'b1;
                    if (mem_ready) begin
                        pc_write = 1'b1;
                        state_d  = ST_IF;
                    end
                end else begin
                    state_d = ST_IF;
                end
            end
            ST_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                state_d   = ST_IF;
                if (cls.load) begin
                    wb_sel = WB_MDR;
                end else if (cls.jal) begin
                    wb_sel    = WB_PC4;
                    pc_source = PC_IMM;
                end else if (cls.jalr) begin
                    wb_sel    = WB_PC4;
                    pc_source = PC_ALU;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IF;
            end
        endcase

        if (reset) begin
            pc_write  = 1'b0;
            pc_source = PC_PLUS4;
            iord      = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            alu_src_a = 1'b0;
            alu_src_b = 1'b0;
            alu_op    = ALU_ADD;
            reg_write = 1'b0;
            wb_sel    = WB_ALU;
            illegal   = 1'b0;
        end
    end

    // Cycle counter freezes in HALT; instret ticks once per PC update.
    always_comb begin
        cycle_cnt_d   = cycle_cnt_q;
        instret_cnt_d = instret_cnt_q;
        if (state_q != ST_HALT) begin
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        end
        if (pc_write) begin
            instret_cnt_d = instret_cnt_q + CNT_W'(1);
        end
    end

    assign halted      = halted_q;
    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;

endmodule
